// File: rtl/fde_sequencer.sv
// Multi-cycle fetch/decode/execute sequencer for the 16-bit datapath.
// Latches the instruction, walks FETCH/DECODE/EXEC/MEM/WB, and drives per-cycle strobes.
module fde_sequencer #(
   parameter int MEM_TIMEOUT = 16,
   parameter int CNT_W       = 5
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        en,
   input  logic [15:0] instr_in,
   input  logic        mem_ready,
   input  logic        flag_eq,
   input  logic        flag_lt,
   input  logic        flag_gt,
   output logic [15:0] ir,
   output logic [3:0]  alu_func,
   output logic        w_en,
   output logic        wb_sel,
   output logic        flag_en,
   output logic        pc_inc,
   output logic        pc_load,
   output logic        mem_en,
   output logic        mem_sel,
   output logic        read_write,
   output logic [2:0]  state,
   output logic        fault
);

   typedef enum logic [2:0] {
      S_FETCH  = 3'd0,
      S_DECODE = 3'd1,
      S_EXEC   = 3'd2,
      S_MEM    = 3'd3,
      S_WB     = 3'd4,
      S_FAULT  = 3'd5
   } state_t;

   localparam bit              TO_EN = (MEM_TIMEOUT != 0);
   localparam logic [CNT_W-1:0] LIMIT = CNT_W'(MEM_TIMEOUT - 1);

   state_t           r_state;
   logic [15:0]      r_ir;
   logic [CNT_W-1:0] r_cnt;
   logic             r_fault;

   logic [3:0] w_op;
   logic       w_act;
   logic       w_timeout;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
   endfunction

   assign w_op      = r_ir[15:12];
   // Strobes are suppressed while stalled or while reset is being applied.
   assign w_act     = en & reset;
   // The current wait cycle is the last one allowed before giving up.
   assign w_timeout = TO_EN && (r_cnt == LIMIT);

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_state <= S_FETCH;
         r_ir    <= 16'h0000;
         r_cnt   <= '0;
         r_fault <= 1'b0;
      end else if (en) begin
         case (r_state)
            S_FETCH: begin
               if (mem_ready) begin
                  r_ir    <= instr_in;
                  r_state <= S_DECODE;
                  r_cnt   <= '0;
               end else if (w_timeout) begin
                  r_state <= S_FAULT;
                  r_fault <= 1'b1;
                  r_cnt   <= '0;
               end else begin
                  r_cnt <= sat_inc(r_cnt);
               end
            end
            S_DECODE: begin
               r_state <= S_EXEC;
               r_cnt   <= '0;
            end
            S_EXEC: begin
               r_state <= (w_op == 4'h8 || w_op == 4'h9) ? S_MEM : S_FETCH;
               r_cnt   <= '0;
            end
            S_MEM: begin
               if (mem_ready) begin
                  r_state <= (w_op == 4'h8) ? S_WB : S_FETCH;
                  r_cnt   <= '0;
               end else if (w_timeout) begin
                  r_state <= S_FAULT;
                  r_fault <= 1'b1;
                  r_cnt   <= '0;
               end else begin
                  r_cnt <= sat_inc(r_cnt);
               end
            end
            S_WB: begin
               r_state <= S_FETCH;
               r_cnt   <= '0;
            end
            S_FAULT: begin
               r_state <= S_FAULT;
            end
            default: begin
               r_state <= S_FETCH;
               r_cnt   <= '0;
            end
         endcase
      end
   end

   always_comb begin
      alu_func   = 4'h0;
      w_en       = 1'b0;
      wb_sel     = 1'b0;
      flag_en    = 1'b0;
      pc_inc     = 1'b0;
      pc_load    = 1'b0;
      mem_en     = 1'b0;
      mem_sel    = 1'b0;
      read_write = 1'b1;
      case (r_state)
         S_FETCH: begin
            mem_en = w_act;
            pc_inc = w_act & mem_ready;
         end
         S_DECODE: begin
            alu_func = w_op;
         end
         S_EXEC: begin
            alu_func = w_op;
            case (w_op)
               4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'hA: w_en = w_act;
               4'hF:    flag_en = w_act;
               4'h0:    pc_load = w_act;
               4'hB:    pc_load = w_act & flag_eq;
               4'hC:    pc_load = w_act & ~flag_eq;
               4'hD:    pc_load = w_act & flag_lt;
               4'hE:    pc_load = w_act & flag_gt;
               default: ;
            endcase
         end
         S_MEM: begin
            mem_en     = w_act;
            mem_sel    = 1'b1;
            read_write = (w_op == 4'h8);
         end
         S_WB: begin
            w_en   = w_act;
            wb_sel = 1'b1;
         end
         default: ;
      endcase
   end

   assign ir    = r_ir;
   assign state = r_state;
   assign fault = r_fault;

endmodule

// File: tb/tb_fde_sequencer.sv
// Directed bench for fde_sequencer: instruction flows, memory waits, stall, timeout and reset.
module tb_fde_sequencer;

   logic        clk = 1'b0;
   logic        reset, en, mem_ready, flag_eq, flag_lt, flag_gt;
   logic [15:0] instr_in;
   logic [15:0] ir;
   logic [3:0]  alu_func;
   logic        w_en, wb_sel, flag_en, pc_inc, pc_load, mem_en, mem_sel, read_write;
   logic [2:0]  state;
   logic        fault;

   int n_pass  = 0;
   int n_total = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   fde_sequencer #(.MEM_TIMEOUT(4), .CNT_W(5)) dut (
      .clk(clk), .reset(reset), .en(en), .instr_in(instr_in), .mem_ready(mem_ready),
      .flag_eq(flag_eq), .flag_lt(flag_lt), .flag_gt(flag_gt),
      .ir(ir), .alu_func(alu_func), .w_en(w_en), .wb_sel(wb_sel), .flag_en(flag_en),
      .pc_inc(pc_inc), .pc_load(pc_load), .mem_en(mem_en), .mem_sel(mem_sel),
      .read_write(read_write), .state(state), .fault(fault)
   );

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_total++;
      assert (obs === exp) begin
         n_pass++;
      end else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chkb(input string tag, input logic obs, input logic exp);
      chk(tag, {15'b0, obs}, {15'b0, exp});
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   // Runs one non-memory instruction from FETCH with zero wait states.
   task automatic run_exec(input string tag, input logic [15:0] instr,
                           input logic eq, input logic lt, input logic gt,
                           input logic ew, input logic ef, input logic ep);
      logic [3:0] op;
      op        = instr[15:12];
      instr_in  = instr;
      flag_eq   = eq;
      flag_lt   = lt;
      flag_gt   = gt;
      mem_ready = 1'b1;
      settle();
      chk({tag, "_fetch_state"}, 16'(state), 16'h0);
      chkb({tag, "_pc_inc"}, pc_inc, 1'b1);
      cyc(); settle();
      chk({tag, "_decode_state"}, 16'(state), 16'h1);
      chk({tag, "_alu_func"}, 16'(alu_func), 16'(op));
      chkb({tag, "_decode_pc_load"}, pc_load, 1'b0);
      cyc(); settle();
      chk({tag, "_exec_state"}, 16'(state), 16'h2);
      chkb({tag, "_w_en"}, w_en, ew);
      chkb({tag, "_flag_en"}, flag_en, ef);
      chkb({tag, "_pc_load"}, pc_load, ep);
      cyc();
   endtask

   initial begin
      reset = 1'b0; en = 1'b1; mem_ready = 1'b0; instr_in = 16'h0000;
      flag_eq = 1'b0; flag_lt = 1'b0; flag_gt = 1'b0;

      // Reset state
      cyc(); cyc(); settle();
      chk("rst_state", 16'(state), 16'h0);
      chk("rst_ir", ir, 16'h0000);
      chkb("rst_fault", fault, 1'b0);
      chkb("rst_mem_en", mem_en, 1'b0);
      chkb("rst_rw", read_write, 1'b1);
      chkb("rst_w_en", w_en, 1'b0);
      reset = 1'b1;

      // ADD with mem_ready tied high: states 0,1,2,0
      instr_in = 16'h1123; mem_ready = 1'b1;
      settle();
      chk("add_s0", 16'(state), 16'h0);
      chkb("add_mem_en", mem_en, 1'b1);
      chkb("add_mem_sel", mem_sel, 1'b0);
      chkb("add_pc_inc", pc_inc, 1'b1);
      chkb("add_w_en_c1", w_en, 1'b0);
      cyc(); settle();
      chk("add_s1", 16'(state), 16'h1);
      chk("add_ir", ir, 16'h1123);
      chkb("add_pc_inc_c2", pc_inc, 1'b0);
      chkb("add_w_en_c2", w_en, 1'b0);
      cyc(); settle();
      chk("add_s2", 16'(state), 16'h2);
      chkb("add_w_en", w_en, 1'b1);
      chkb("add_wb_sel", wb_sel, 1'b0);
      chk("add_alu_func", 16'(alu_func), 16'h1);
      cyc(); settle();
      chk("add_back_fetch", 16'(state), 16'h0);
      chk("add_alu_func_fetch", 16'(alu_func), 16'h0);

      // LD with two memory wait cycles: 7 cycles total
      instr_in = 16'h8456; mem_ready = 1'b1;
      cyc(); settle();
      chk("ld_s1", 16'(state), 16'h1);
      cyc(); settle();
      chk("ld_s2", 16'(state), 16'h2);
      chkb("ld_exec_w_en", w_en, 1'b0);
      cyc(); mem_ready = 1'b0; settle();
      chk("ld_mem1", 16'(state), 16'h3);
      chkb("ld_mem_en", mem_en, 1'b1);
      chkb("ld_mem_sel", mem_sel, 1'b1);
      chkb("ld_rw", read_write, 1'b1);
      cyc(); settle();
      chk("ld_mem2", 16'(state), 16'h3);
      cyc(); mem_ready = 1'b1; settle();
      chk("ld_mem3", 16'(state), 16'h3);
      cyc(); settle();
      chk("ld_wb", 16'(state), 16'h4);
      chkb("ld_wb_w_en", w_en, 1'b1);
      chkb("ld_wb_sel", wb_sel, 1'b1);
      chkb("ld_wb_mem_en", mem_en, 1'b0);
      cyc(); settle();
      chk("ld_done", 16'(state), 16'h0);
      chkb("ld_fault", fault, 1'b0);

      // Branches, jump, compare, logic and move
      run_exec("be_t",  16'hB000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      run_exec("be_f",  16'hB000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      run_exec("bne_t", 16'hC000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      run_exec("bne_f", 16'hC000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      run_exec("blt_t", 16'hD000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
      run_exec("bgt_f", 16'hE000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      run_exec("bgt_t", 16'hE000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
      run_exec("jmp",   16'h0042, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      run_exec("cmp",   16'hF012, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      run_exec("xor",   16'h6345, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      run_exec("mov",   16'hA100, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      flag_eq = 1'b0; flag_lt = 1'b0; flag_gt = 1'b0;

      // ST stalled by en=0 for 5 cycles while in MEM
      instr_in = 16'h9010; mem_ready = 1'b1;
      cyc(); cyc(); cyc(); mem_ready = 1'b0; settle();
      chk("st_mem", 16'(state), 16'h3);
      chkb("st_rw", read_write, 1'b0);
      chkb("st_mem_sel", mem_sel, 1'b1);
      chkb("st_mem_en", mem_en, 1'b1);
      cyc(); en = 1'b0; settle();
      chkb("st_stall_mem_en", mem_en, 1'b0);
      for (int i = 0; i < 5; i++) begin
         cyc(); settle();
         chk("st_stall_state", 16'(state), 16'h3);
         chkb("st_stall_mem_en_hold", mem_en, 1'b0);
      end
      en = 1'b1; mem_ready = 1'b1; settle();
      chk("st_resume_state", 16'(state), 16'h3);
      chkb("st_resume_mem_en", mem_en, 1'b1);
      cyc(); mem_ready = 1'b0; settle();
      chk("st_done", 16'(state), 16'h0);
      chkb("st_done_w_en", w_en, 1'b0);
      chkb("st_done_pc_inc", pc_inc, 1'b0);
      chkb("st_done_fault", fault, 1'b0);

      // Fetch timeout: 4 wait cycles then FAULT
      for (int i = 0; i < 4; i++) begin
         settle();
         chk("to_wait_state", 16'(state), 16'h0);
         cyc();
      end
      settle();
      chk("to_fault_state", 16'(state), 16'h5);
      chkb("to_fault", fault, 1'b1);
      chkb("to_fault_mem_en", mem_en, 1'b0);
      mem_ready = 1'b1; instr_in = 16'h1123;
      cyc(); cyc(); settle();
      chk("to_fault_sticky", 16'(state), 16'h5);
      chkb("to_fault_pc_inc", pc_inc, 1'b0);
      reset = 1'b0; mem_ready = 1'b0;
      cyc(); settle();
      chk("to_rst_state", 16'(state), 16'h0);
      chkb("to_rst_fault", fault, 1'b0);
      reset = 1'b1;

      // mem_ready on the 4th wait cycle rescues the fetch
      for (int i = 0; i < 3; i++) begin
         settle();
         chk("rescue_wait_state", 16'(state), 16'h0);
         cyc();
      end
      mem_ready = 1'b1; instr_in = 16'h2222; settle();
      chkb("rescue_pc_inc", pc_inc, 1'b1);
      cyc(); settle();
      chk("rescue_decode", 16'(state), 16'h1);
      chkb("rescue_no_fault", fault, 1'b0);
      chk("rescue_ir", ir, 16'h2222);
      cyc(); cyc(); settle();
      chk("rescue_done", 16'(state), 16'h0);

      // Reset during CMP EXEC aborts the flag load
      instr_in = 16'hF123; mem_ready = 1'b1;
      cyc(); mem_ready = 1'b0; settle();
      chkb("cmprst_dec_flag_en", flag_en, 1'b0);
      cyc(); reset = 1'b0; settle();
      chk("cmprst_exec_state", 16'(state), 16'h2);
      chkb("cmprst_exec_flag_en", flag_en, 1'b0);
      cyc(); settle();
      chk("cmprst_state", 16'(state), 16'h0);
      chk("cmprst_ir", ir, 16'h0000);
      chkb("cmprst_flag_en", flag_en, 1'b0);
      reset = 1'b1; settle();
      chkb("cmprst_after_flag_en", flag_en, 1'b0);
      chkb("cmprst_after_mem_en", mem_en, 1'b1);
      chkb("cmprst_after_fault", fault, 1'b0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
